// File: rtl/my_alu_seq.sv
// Sequential ALU: registered single-cycle arithmetic/logic/shift ops plus
// iterative unsigned multiply, divide and remainder behind a valid/ready handshake.
module my_alu_seq #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic             in_valid,
    output logic             out_ready,
    input  logic [4:0]       in_op,
    input  logic [WIDTH-1:0] in_A,
    input  logic [WIDTH-1:0] in_B,
    input  logic             in_cf,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_C,
    output logic             out_zf,
    output logic             out_nf,
    output logic             out_cf,
    output logic             out_err
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_ADC  = 5'b00001;
    localparam logic [4:0] OP_SUB  = 5'b00010;
    localparam logic [4:0] OP_SBC  = 5'b00011;
    localparam logic [4:0] OP_AND  = 5'b00100;
    localparam logic [4:0] OP_OR   = 5'b00101;
    localparam logic [4:0] OP_XOR  = 5'b00110;
    localparam logic [4:0] OP_NOT  = 5'b00111;
    localparam logic [4:0] OP_SLL  = 5'b01000;
    localparam logic [4:0] OP_SRL  = 5'b01001;
    localparam logic [4:0] OP_SRA  = 5'b01010;
    localparam logic [4:0] OP_MUL  = 5'b01011;
    localparam logic [4:0] OP_DIVU = 5'b01100;
    localparam logic [4:0] OP_REMU = 5'b01101;

    typedef enum logic {IDLE, ITER} state_t;

    state_t           state_reg, state_next;
    logic [4:0]       op_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] lo_reg;
    logic [WIDTH-1:0] opnd_reg;

    logic             accept;
    logic             multi_op;
    logic             last_iter;
    logic [SHW-1:0]   shamt;

    assign accept    = in_valid && (state_reg == IDLE);
    assign multi_op  = (in_op == OP_MUL) || (in_op == OP_DIVU) || (in_op == OP_REMU);
    assign last_iter = (cnt_reg == CW'(WIDTH - 1));
    assign shamt     = in_B[SHW-1:0];

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        out_ready  = 1'b0;
        case (state_reg)
            IDLE: begin
                out_ready = 1'b1;
                if (accept && multi_op) begin
                    state_next = ITER;
                end
            end
            ITER: begin
                if (last_iter) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Single-cycle result; shifts carry an extra bit on the exit side to catch the last bit out.
    logic [WIDTH-1:0] sc_c;
    logic             sc_cf;
    logic             sc_legal;
    logic [WIDTH:0]   sc_ext;

    always_comb begin
        sc_c     = '0;
        sc_cf    = 1'b0;
        sc_legal = 1'b1;
        sc_ext   = '0;
        case (in_op)
            OP_ADD: begin
                sc_ext        = {1'b0, in_A} + {1'b0, in_B};
                {sc_cf, sc_c} = sc_ext;
            end
            OP_ADC: begin
                sc_ext        = {1'b0, in_A} + {1'b0, in_B} + (WIDTH+1)'(in_cf);
                {sc_cf, sc_c} = sc_ext;
            end
            OP_SUB: begin
                sc_ext        = {1'b0, in_A} - {1'b0, in_B};
                {sc_cf, sc_c} = sc_ext;
            end
            OP_SBC: begin
                sc_ext        = {1'b0, in_A} - {1'b0, in_B} - (WIDTH+1)'(in_cf);
                {sc_cf, sc_c} = sc_ext;
            end
            OP_AND: sc_c = in_A & in_B;
            OP_OR:  sc_c = in_A | in_B;
            OP_XOR: sc_c = in_A ^ in_B;
            OP_NOT: sc_c = ~in_A;
            OP_SLL: begin
                sc_ext        = {1'b0, in_A} << shamt;
                {sc_cf, sc_c} = sc_ext;
            end
            OP_SRL: begin
                sc_ext        = {in_A, 1'b0} >> shamt;
                {sc_c, sc_cf} = sc_ext;
            end
            OP_SRA: begin
                sc_ext        = $unsigned($signed({in_A, 1'b0}) >>> shamt);
                {sc_c, sc_cf} = sc_ext;
            end
            OP_MUL, OP_DIVU, OP_REMU: sc_legal = 1'b1;
            default: sc_legal = 1'b0;
        endcase
    end

    // One iteration of shift-add multiply ({acc,lo} = {high,multiplier}) or restoring
    // division (acc = partial remainder, lo = dividend shifting into quotient).
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_neg;
    logic [WIDTH-1:0] step_acc;
    logic [WIDTH-1:0] step_lo;
    logic [WIDTH-1:0] mc_c;
    logic             mc_cf;
    logic             mc_err;
    logic             is_mul;

    always_comb begin
        is_mul    = (op_reg == OP_MUL);
        mul_sum   = {1'b0, acc_reg} + (lo_reg[0] ? {1'b0, opnd_reg} : '0);
        div_shift = {acc_reg, lo_reg[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_reg};
        div_neg   = div_diff[WIDTH];
        step_acc  = '0;
        step_lo   = '0;
        mc_c      = '0;
        mc_cf     = 1'b0;
        mc_err    = 1'b0;
        if (is_mul) begin
            step_acc = mul_sum[WIDTH:1];
            step_lo  = {mul_sum[0], lo_reg[WIDTH-1:1]};
            mc_c     = step_lo;
            mc_cf    = |step_acc;
        end else begin
            step_acc = div_neg ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
            step_lo  = {lo_reg[WIDTH-2:0], ~div_neg};
            mc_c     = (op_reg == OP_DIVU) ? step_lo : step_acc;
            mc_err   = (opnd_reg == '0);
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            op_reg    <= '0;
            cnt_reg   <= '0;
            acc_reg   <= '0;
            lo_reg    <= '0;
            opnd_reg  <= '0;
            out_valid <= 1'b0;
            out_C     <= '0;
            out_zf    <= 1'b0;
            out_nf    <= 1'b0;
            out_cf    <= 1'b0;
            out_err   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (state_reg == IDLE) begin
                if (accept && multi_op) begin
                    op_reg   <= in_op;
                    cnt_reg  <= '0;
                    acc_reg  <= '0;
                    lo_reg   <= (in_op == OP_MUL) ? in_B : in_A;
                    opnd_reg <= (in_op == OP_MUL) ? in_A : in_B;
                end else if (accept) begin
                    out_valid <= 1'b1;
                    out_C     <= sc_c;
                    out_err   <= ~sc_legal;
                    // Illegal opcodes leave the status flags untouched.
                    if (sc_legal) begin
                        out_zf <= (sc_c == '0);
                        out_nf <= sc_c[WIDTH-1];
                        out_cf <= sc_cf;
                    end
                end
            end else begin
                acc_reg <= step_acc;
                lo_reg  <= step_lo;
                cnt_reg <= cnt_reg + 1'b1;
                if (last_iter) begin
                    out_valid <= 1'b1;
                    out_C     <= mc_c;
                    out_zf    <= (mc_c == '0);
                    out_nf    <= mc_c[WIDTH-1];
                    out_cf    <= mc_cf;
                    out_err   <= mc_err;
                end
            end
        end
    end

endmodule

// File: tb/tb_my_alu_seq.sv
// Self-checking bench for my_alu_seq (WIDTH=16): directed and random ops against
// an arithmetic reference model of the opcode table.
module tb_my_alu_seq;

    localparam int W = 16;
    localparam longint unsigned MASK = 64'hFFFF;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready;
    logic [4:0]   in_op = '0;
    logic [W-1:0] in_A = '0;
    logic [W-1:0] in_B = '0;
    logic         in_cf = 1'b0;
    logic         out_valid;
    logic [W-1:0] out_C;
    logic         out_zf, out_nf, out_cf, out_err;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    logic         m_zf = 1'b0, m_nf = 1'b0, m_cf = 1'b0;
    logic [W-1:0] exp_c;
    logic         exp_err;

    my_alu_seq #(.WIDTH(W)) dut (
        .in_clk   (clk),
        .in_rst   (rst),
        .in_valid (in_valid),
        .out_ready(out_ready),
        .in_op    (in_op),
        .in_A     (in_A),
        .in_B     (in_B),
        .in_cf    (in_cf),
        .out_valid(out_valid),
        .out_C    (out_C),
        .out_zf   (out_zf),
        .out_nf   (out_nf),
        .out_cf   (out_cf),
        .out_err  (out_err)
    );

    always #5 clk = ~clk;

    task automatic model(input int op, input longint unsigned a, input longint unsigned b, input int ci);
        longint unsigned r;
        longint          sa;
        longint unsigned s;
        logic            f;
        s = b & 15;
        f = 1'b0;
        r = 0;
        exp_err = 1'b0;
        case (op)
            0:  begin r = a + b;      f = r[16]; end
            1:  begin r = a + b + ci; f = r[16]; end
            2:  begin r = a - b;      f = (a < b); end
            3:  begin r = a - b - ci; f = (a < b + ci); end
            4:  r = a & b;
            5:  r = a | b;
            6:  r = a ^ b;
            7:  r = ~a;
            8:  begin r = a << s; f = (s != 0) ? ((a >> (16 - s)) & 1) != 0 : 1'b0; end
            9:  begin r = a >> s; f = (s != 0) ? ((a >> (s - 1)) & 1) != 0 : 1'b0; end
            10: begin
                sa = (a >= 32768) ? longint'(a) - 65536 : longint'(a);
                r  = longint'(sa >>> s);
                f  = (s != 0) ? ((a >> (s - 1)) & 1) != 0 : 1'b0;
            end
            11: begin r = a * b; f = (r >> 16) != 0; end
            12: begin if (b == 0) begin r = MASK; exp_err = 1'b1; end else r = a / b; end
            13: begin if (b == 0) begin r = a; exp_err = 1'b1; end else r = a % b; end
            default: begin
                exp_c   = '0;
                exp_err = 1'b1;
                return;
            end
        endcase
        exp_c = W'(r & MASK);
        m_zf  = (exp_c == 0);
        m_nf  = exp_c[W-1];
        m_cf  = f;
    endtask

    // Drives one request and waits (bounded) for out_valid; reports cycles after acceptance.
    task automatic issue(input int op, input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                         output int lat, output logic ready_after);
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = 5'(op);
        in_A     = a;
        in_B     = b;
        in_cf    = ci;
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        ready_after = out_ready;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m_zf = 0; m_nf = 0; m_cf = 0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({out_C, out_zf, out_nf, out_cf, out_err, out_valid} !== {16'h0, 5'b0}) begin
            n_bad++;
            $display("FAIL reset_outputs: got C=%h flags=%b%b%b%b v=%b, want all zero", out_C, out_zf, out_nf, out_cf, out_err, out_valid);
        end
        n_cmp++;
        if (out_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready: got %b want 1", out_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        $display("reset released");
    endtask

    task automatic test_directed_single();
        int          ops[5]  = '{0, 0, 2, 3, 10};
        logic [15:0] as[5]   = '{16'd3, 16'hFFFF, 16'd3, 16'd5, 16'h8001};
        logic [15:0] bs[5]   = '{16'd4, 16'd1, 16'd4, 16'd2, 16'd1};
        logic        cis[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [15:0] want[5] = '{16'd7, 16'h0, 16'hFFFF, 16'd2, 16'hC000};
        logic        wcf[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        int   lat;
        logic rdy;
        for (int i = 0; i < 5; i++) begin
            issue(ops[i], as[i], bs[i], cis[i], lat, rdy);
            model(ops[i], as[i], bs[i], cis[i]);
            n_cmp++;
            if (lat !== 0) begin
                n_bad++;
                $display("FAIL single_latency[%0d]: got %0d want 0", i, lat);
            end
            n_cmp++;
            if ({out_C, out_cf} !== {want[i], wcf[i]} ||
                {out_zf, out_nf, out_err} !== {m_zf, m_nf, 1'b0}) begin
                n_bad++;
                $display("FAIL single_directed[%0d]: got C=%h z%b n%b c%b e%b want C=%h z%b n%b c%b e0",
                         i, out_C, out_zf, out_nf, out_cf, out_err, want[i], m_zf, m_nf, wcf[i]);
            end
            $display("op %0d A=%h B=%h cf=%b -> C=%h", ops[i], as[i], bs[i], cis[i], out_C);
            @(posedge clk);
            #1;
            n_cmp++;
            if (out_valid !== 1'b0 || out_C !== want[i]) begin
                n_bad++;
                $display("FAIL single_pulse_hold[%0d]: got v=%b C=%h want v=0 C=%h", i, out_valid, out_C, want[i]);
            end
        end
    endtask

    task automatic test_random_single();
        int          op;
        logic [15:0] a, b;
        logic        ci;
        int          lat;
        logic        rdy;
        for (int i = 0; i < 40; i++) begin
            op = ($urandom_range(0, 7) == 0) ? int'($urandom_range(14, 31)) : int'($urandom_range(0, 10));
            a  = 16'($urandom);
            b  = 16'($urandom);
            ci = 1'($urandom);
            issue(op, a, b, ci, lat, rdy);
            model(op, a, b, ci);
            n_cmp++;
            if (lat !== 0 || {out_C, out_zf, out_nf, out_cf, out_err} !== {exp_c, m_zf, m_nf, m_cf, exp_err}) begin
                n_bad++;
                $display("FAIL random_single[%0d] op=%0d A=%h B=%h: got lat=%0d C=%h z%b n%b c%b e%b want C=%h z%b n%b c%b e%b",
                         i, op, a, b, lat, out_C, out_zf, out_nf, out_cf, out_err, exp_c, m_zf, m_nf, m_cf, exp_err);
            end
            $display("rand op %0d A=%h B=%h -> C=%h", op, a, b, out_C);
        end
    endtask

    task automatic test_back_to_back();
        int          ops[8];
        logic [15:0] as[8], bs[8];
        logic        cis[8];
        for (int i = 0; i < 8; i++) begin
            ops[i] = int'($urandom_range(0, 10));
            as[i]  = 16'($urandom);
            bs[i]  = 16'($urandom);
            cis[i] = 1'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_op = 5'(ops[0]); in_A = as[0]; in_B = bs[0]; in_cf = cis[0];
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            model(ops[i], as[i], bs[i], cis[i]);
            n_cmp++;
            if (out_valid !== 1'b1 || out_ready !== 1'b1 ||
                {out_C, out_zf, out_nf, out_cf, out_err} !== {exp_c, m_zf, m_nf, m_cf, exp_err}) begin
                n_bad++;
                $display("FAIL back_to_back[%0d]: got v=%b C=%h flags=%b%b%b%b want v=1 C=%h flags=%b%b%b%b",
                         i, out_valid, out_C, out_zf, out_nf, out_cf, out_err, exp_c, m_zf, m_nf, m_cf, exp_err);
            end
            $display("b2b op %0d A=%h B=%h -> C=%h", ops[i], as[i], bs[i], out_C);
            if (i < 7) begin
                in_op = 5'(ops[i+1]); in_A = as[i+1]; in_B = bs[i+1]; in_cf = cis[i+1];
            end else begin
                in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_multi();
        int          ops[5]  = '{11, 12, 13, 12, 13};
        logic [15:0] as[5]   = '{16'd300, 16'd100, 16'd100, 16'd5, 16'd5};
        logic [15:0] bs[5]   = '{16'd300, 16'd7, 16'd7, 16'd0, 16'd0};
        logic [15:0] want[5] = '{16'h5F90, 16'd14, 16'd2, 16'hFFFF, 16'd5};
        logic        werr[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int          op, lat;
        logic        rdy;
        logic [15:0] a, b;
        for (int i = 0; i < 25; i++) begin
            if (i < 5) begin
                op = ops[i]; a = as[i]; b = bs[i];
            end else begin
                op = int'($urandom_range(11, 13));
                a  = 16'($urandom);
                b  = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom >> $urandom_range(0, 16));
            end
            issue(op, a, b, 1'b0, lat, rdy);
            model(op, a, b, 0);
            n_cmp++;
            if (rdy !== 1'b0 || lat !== 16 || out_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL multi_timing[%0d]: got ready_after=%b lat=%0d ready_at_result=%b want 0/16/1", i, rdy, lat, out_ready);
            end
            n_cmp++;
            if ({out_C, out_zf, out_nf, out_cf, out_err} !== {exp_c, m_zf, m_nf, m_cf, exp_err} ||
                (i < 5 && (out_C !== want[i] || out_err !== werr[i]))) begin
                n_bad++;
                $display("FAIL multi_result[%0d] op=%0d A=%h B=%h: got C=%h z%b n%b c%b e%b want C=%h z%b n%b c%b e%b",
                         i, op, a, b, out_C, out_zf, out_nf, out_cf, out_err, exp_c, m_zf, m_nf, m_cf, exp_err);
            end
            $display("multi op %0d A=%h B=%h -> C=%h err=%b", op, a, b, out_C, out_err);
        end
    endtask

    task automatic test_busy_ignore();
        int pulses = 0;
        int first  = -1;
        @(negedge clk);
        in_valid = 1'b1; in_op = 5'd11; in_A = 16'd300; in_B = 16'd300; in_cf = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        model(11, 300, 300, 0);
        for (int c = 1; c <= 24; c++) begin
            if (c == 3) begin
                in_valid = 1'b1; in_op = 5'd0; in_A = 16'd1; in_B = 16'd1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            if (out_valid) begin
                pulses++;
                if (first < 0) first = c;
            end
        end
        n_cmp++;
        if (pulses !== 1 || first !== 16 || out_C !== 16'h5F90 || out_cf !== 1'b1) begin
            n_bad++;
            $display("FAIL busy_ignore: got pulses=%0d at=%0d C=%h cf=%b want 1/16/5f90/1", pulses, first, out_C, out_cf);
        end
        $display("busy ignore MUL 300*300 -> C=%h pulses=%0d", out_C, pulses);
    endtask

    task automatic test_illegal();
        int   lat;
        logic rdy;
        issue(2, 16'd3, 16'd4, 1'b0, lat, rdy);
        model(2, 3, 4, 0);
        issue(31, 16'h1234, 16'h5678, 1'b0, lat, rdy);
        model(31, 16'h1234, 16'h5678, 0);
        n_cmp++;
        if ({out_C, out_zf, out_nf, out_cf, out_err} !== {16'h0, 1'b0, 1'b1, 1'b1, 1'b1} || lat !== 0) begin
            n_bad++;
            $display("FAIL illegal_op: got C=%h z%b n%b c%b e%b lat=%0d want C=0000 z0 n1 c1 e1 lat=0",
                     out_C, out_zf, out_nf, out_cf, out_err, lat);
        end
        $display("illegal op 31 -> C=%h err=%b", out_C, out_err);
        issue(0, 16'd1, 16'd2, 1'b0, lat, rdy);
        model(0, 1, 2, 0);
        n_cmp++;
        if ({out_C, out_zf, out_nf, out_cf, out_err} !== {16'd3, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL illegal_clear: got C=%h z%b n%b c%b e%b want C=0003 z0 n0 c0 e0", out_C, out_zf, out_nf, out_cf, out_err);
        end
        $display("ADD 1+2 after illegal -> C=%h err=%b", out_C, out_err);
    endtask

    task automatic test_reset_mid();
        int   seen = 0;
        int   lat;
        logic rdy;
        @(negedge clk);
        in_valid = 1'b1; in_op = 5'd11; in_A = 16'h1234; in_B = 16'h00FF; in_cf = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({out_C, out_zf, out_nf, out_cf, out_err, out_valid, out_ready} !== {16'h0, 6'b000001}) begin
            n_bad++;
            $display("FAIL reset_mid_outputs: got C=%h z%b n%b c%b e%b v=%b r=%b want zeros, ready=1",
                     out_C, out_zf, out_nf, out_cf, out_err, out_valid, out_ready);
        end
        m_zf = 0; m_nf = 0; m_cf = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        n_cmp++;
        if (seen !== 0 || out_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid_abort: got valid pulses=%0d ready=%b want 0/1", seen, out_ready);
        end
        issue(0, 16'd1, 16'd1, 1'b0, lat, rdy);
        model(0, 1, 1, 0);
        n_cmp++;
        if (lat !== 0 || {out_C, out_zf, out_nf, out_cf, out_err} !== {16'd2, 4'b0000}) begin
            n_bad++;
            $display("FAIL reset_mid_add: got lat=%0d C=%h flags=%b%b%b%b want lat=0 C=0002 flags=0000",
                     lat, out_C, out_zf, out_nf, out_cf, out_err);
        end
        $display("after mid-op reset ADD 1+1 -> C=%h", out_C);
    endtask

    initial begin
        test_reset();
        test_directed_single();
        test_random_single();
        test_back_to_back();
        test_multi();
        test_busy_ignore();
        test_illegal();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/my_alu_seq.md
# my_alu_seq

Parametrised sequential successor to the single-cycle `my_ALU`. It registers every result and its flags and accepts one operation at a time through a valid/ready handshake. It adds multi-cycle unsigned multiply, divide and remainder alongside the existing single-cycle arithmetic, logic and shift ops. It sits between the decode/operand-fetch stage and writeback in the processor datapath.

## Interface
- `WIDTH`, default 16: operand and result width; legal values are 8 or more and even.
- `SHW`, default `$clog2(WIDTH)`: number of shift-amount bits taken from `in_B`.
- `in_clk`, in, 1: the single clock; all state updates on the rising edge.
- `in_rst`, in, 1: reset, asynchronous, active-high.
- `in_valid`, in, 1: operation request.
- `out_ready`, out, 1: block can accept a request; an op is accepted on a rising edge where `in_valid & out_ready`.
- `in_op`, in, 5: opcode, sampled on acceptance.
- `in_A`, in, WIDTH: operand A, sampled on acceptance.
- `in_B`, in, WIDTH: operand B, sampled on acceptance.
- `in_cf`, in, 1: carry/borrow input for ADC and SBC, sampled on acceptance.
- `out_valid`, out, 1: one-cycle pulse indicating a new result.
- `out_C`, out, WIDTH: result, held until the next result.
- `out_zf`, `out_nf`, `out_cf`, out, 1 each: zero, negative (MSB) and carry flags, held with `out_C`.
- `out_err`, out, 1: illegal opcode or divide-by-zero, held with `out_C`.

## Operation
- Opcodes, single-cycle:
  - 00000 ADD: A+B
  - 00001 ADC: A+B+cf
  - 00010 SUB: A−B
  - 00011 SBC: A−B−cf
  - 00100 AND
  - 00101 OR
  - 00110 XOR
  - 00111 NOT A
  - 01000 SLL
  - 01001 SRL
  - 01010 SRA; shift amount is `B[SHW-1:0]`.
- Opcodes, multi-cycle: 01011 MUL (low WIDTH bits of the unsigned product), 01100 DIVU (quotient), 01101 REMU (remainder).
- Any other opcode is illegal: single-cycle, `out_C`=0, `out_err`=1, and `out_zf`, `out_nf`, `out_cf` keep their previous values.
- Carry rules:
  - ADD/ADC: cf is the carry out of bit WIDTH−1.
  - SUB/SBC: cf is the borrow, i.e. 1 when unsigned A < B (+cf for SBC).
  - Logic ops: cf=0.
  - Shifts: cf is the last bit shifted out; cf=0 when the shift amount is 0.
  - MUL: cf=1 when the high half of the product is non-zero.
  - DIVU/REMU: cf=0.
- `out_zf` = (out_C==0) and `out_nf` = out_C[WIDTH−1] for every legal op.
- MUL is an iterative shift-add, 1 bit per cycle, WIDTH iterations.
- DIVU/REMU use iterative restoring division, 1 bit per cycle, WIDTH iterations.
- Divide by zero: DIVU gives all ones, REMU gives A; `out_err`=1, cf=0. Latency is unchanged from a normal divide.
- FSM states:
  - IDLE: `out_ready`=1. Accepting a single-cycle op stays in IDLE. Accepting MUL/DIVU/REMU loads the operands, clears the iteration counter and moves to ITER.
  - ITER: `out_ready`=0. Runs one iteration per cycle. When the counter reaches WIDTH−1, it writes the result and flags, pulses `out_valid` and returns to IDLE.
- `in_valid` while `out_ready`=0 is ignored; no request is queued.
- Reset values: `out_C`=0, all flags 0, `out_err`=0, `out_valid`=0, `out_ready`=1, FSM in IDLE, counter 0.
- Asserting reset mid-operation aborts the op; no `out_valid` is produced.

## Timing
- Single-cycle op accepted at edge k: result, flags and `out_valid`=1 are visible after edge k, for exactly one cycle.
- Back-to-back single-cycle ops sustain 1 op per cycle.
- Multi-cycle op accepted at edge k:
  - `out_ready` is low after edge k.
  - Result and `out_valid` appear after edge k+WIDTH.
  - `out_ready` returns high in the same cycle, so a new op can be accepted at edge k+WIDTH+1.
- `out_C` and the flags change only in a cycle where `out_valid` is 1.

## Test plan
All scenarios use WIDTH=16.
- ADD A=3, B=4 -> `out_C`=7, zf=0, nf=0, cf=0, `out_valid` one cycle after acceptance. Then ADD 0xFFFF+1 -> `out_C`=0, zf=1, cf=1.
- SUB A=3, B=4 -> 0xFFFF, nf=1, cf=1. Then SBC A=5, B=2, in_cf=1 -> 2, cf=0. Then SRA A=0x8001, B=1 -> 0xC000, cf=1.
- MUL 300×300 -> `out_C`=0x5F90, cf=1. `out_ready` is low for 16 cycles and `out_valid` comes 16 cycles after acceptance. An `in_valid` pulse with ADD during this window is ignored, with no extra `out_valid`.
- DIVU 100/7 -> 14. REMU 100/7 -> 2. DIVU 5/0 -> 0xFFFF with `out_err`=1. REMU 5/0 -> 5 with `out_err`=1.
- Opcode 11111 -> `out_C`=0, `out_err`=1, previous flags unchanged. A following legal ADD clears `out_err`.
- Assert `in_rst` 5 cycles into a MUL -> all outputs return to reset values immediately, no `out_valid`. After release, `out_ready`=1 and ADD 1+1 gives 2.
